// File: rtl/ps2_host_tx_pkg.sv
// Shared PS/2 host-transmit definitions: FSM states, frame edge numbering and default cycle counts.
// Also imported by the keyboard receive path.
package ps2_host_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INHIBIT,
        ST_RELEASE,
        ST_XFER,
        ST_WAIT_IDLE
    } ps2_tx_state_e;

    // Device clock falling-edge numbers within a host-to-device frame.
    localparam logic [3:0] EDGE_LAST_DATA = 4'd8;
    localparam logic [3:0] EDGE_PARITY    = 4'd9;
    localparam logic [3:0] EDGE_STOP      = 4'd10;
    localparam logic [3:0] EDGE_ACK       = 4'd11;

    localparam int unsigned DEF_INHIBIT_CYCLES = 5000;
    localparam int unsigned DEF_TIMEOUT_CYCLES = 750000;

    function automatic logic odd_parity(input logic [7:0] b);
        return ~^b;
    endfunction

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Two-flop synchroniser for a raw PS/2 pin plus a falling-edge pulse on the synchronised level.
// Flops reset high to match an idle (released) bus, so reset never produces a false edge.
module ps2_sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic pin,
    output logic sync,
    output logic fall
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;
    logic prev_q, prev_d;

    always_comb begin
        meta_d = pin;
        sync_d = meta_q;
        prev_d = sync_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign sync = sync_q;
    assign fall = prev_q & ~sync_q;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, issues a start bit, then shifts one command
// byte out on device clock falling edges and checks the device ACK.
module ps2_host_tx
    import ps2_host_tx_pkg::*;
#(
    parameter int unsigned INHIBIT_CYCLES = DEF_INHIBIT_CYCLES,
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_done,
    output logic       tx_error,
    output logic       busy,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic       ps2_clk_drive_low,
    output logic       ps2_dat_drive_low
);

    localparam int unsigned CNT_W = $clog2(max_u(INHIBIT_CYCLES, TIMEOUT_CYCLES) + 1);
    localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    ps2_tx_state_e    state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       n_q, n_d, n_inc;
    logic [7:0]       shift_q, shift_d;
    logic             parity_q, parity_d;
    logic             clk_drive_q, clk_drive_d;
    logic             dat_drive_q, dat_drive_d;

    logic clk_sync, clk_fall;
    logic dat_sync, dat_fall_unused;
    logic accept, done, error, watched, timeout;

    ps2_sync_edge u_clk_sync (
        .clk   (CLOCK_50),
        .reset (reset),
        .pin   (ps2_clk_in),
        .sync  (clk_sync),
        .fall  (clk_fall)
    );

    ps2_sync_edge u_dat_sync (
        .clk   (CLOCK_50),
        .reset (reset),
        .pin   (ps2_dat_in),
        .sync  (dat_sync),
        .fall  (dat_fall_unused)
    );

    assign tx_ready = (state_q == ST_IDLE) && !reset;
    assign busy     = (state_q != ST_IDLE);
    assign accept   = tx_valid && tx_ready;
    assign n_inc    = (n_q == EDGE_ACK) ? EDGE_ACK : n_q + 4'd1;
    assign watched  = state_q inside {ST_RELEASE, ST_XFER, ST_WAIT_IDLE};
    assign timeout  = watched && !clk_fall && (cnt_q == TMO_LAST);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        n_d         = n_q;
        shift_d     = shift_q;
        parity_d    = parity_q;
        dat_drive_d = dat_drive_q;
        done        = 1'b0;
        error       = 1'b0;

        if (watched) begin
            cnt_d = clk_fall ? '0 : cnt_q + CNT_W'(1);
        end

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                n_d   = '0;
                if (accept) begin
                    shift_d     = tx_data;
                    parity_d    = odd_parity(tx_data);
                    dat_drive_d = (INH_LAST == '0);
                    state_d     = ST_INHIBIT;
                end
            end
            ST_INHIBIT: begin
                // Drive outputs are registered, so the start bit is raised one cycle early
                // to coincide with the final inhibit cycle.
                if (cnt_q == INH_LAST) begin
                    cnt_d       = '0;
                    dat_drive_d = 1'b1;
                    state_d     = ST_RELEASE;
                end else begin
                    cnt_d       = cnt_q + CNT_W'(1);
                    dat_drive_d = ((cnt_q + CNT_W'(1)) == INH_LAST);
                end
            end
            ST_RELEASE: begin
                n_d         = '0;
                dat_drive_d = 1'b1;
                state_d     = ST_XFER;
            end
            ST_XFER: begin
                if (clk_fall) begin
                    n_d = n_inc;
                    if (n_inc <= EDGE_LAST_DATA) begin
                        dat_drive_d = ~shift_q[0];
                        shift_d     = {1'b0, shift_q[7:1]};
                    end else if (n_inc == EDGE_PARITY) begin
                        dat_drive_d = ~parity_q;
                    end else if (n_inc == EDGE_STOP) begin
                        dat_drive_d = 1'b0;
                    end else if (dat_sync) begin
                        error   = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_WAIT_IDLE;
                    end
                end
            end
            ST_WAIT_IDLE: begin
                dat_drive_d = 1'b0;
                if (clk_sync && dat_sync) begin
                    done    = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (timeout && !done && !error) begin
            error   = 1'b1;
            state_d = ST_IDLE;
        end

        if (state_d == ST_IDLE) begin
            dat_drive_d = 1'b0;
            cnt_d       = '0;
        end
        clk_drive_d = (state_d == ST_INHIBIT);
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            n_q         <= '0;
            shift_q     <= '0;
            parity_q    <= 1'b0;
            clk_drive_q <= 1'b0;
            dat_drive_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            n_q         <= n_d;
            shift_q     <= shift_d;
            parity_q    <= parity_d;
            clk_drive_q <= clk_drive_d;
            dat_drive_q <= dat_drive_d;
        end
    end

    assign tx_done           = done && !reset;
    assign tx_error          = error && !reset;
    assign ps2_clk_drive_low = clk_drive_q;
    assign ps2_dat_drive_low = dat_drive_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: an open-drain bus with a behavioural keyboard that clocks the frame,
// samples data on rising edges and optionally ACKs; frames are checked against a byte-level model.
module tb_ps2_host_tx;

    localparam int unsigned INH  = 20;
    localparam int unsigned TMO  = 400;
    localparam int unsigned HALF = 20;

    logic       CLOCK_50 = 1'b0;
    logic       reset    = 1'b1;
    logic [7:0] tx_data  = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready, tx_done, tx_error, busy;
    logic       ps2_clk_in, ps2_dat_in;
    logic       ps2_clk_drive_low, ps2_dat_drive_low;
    logic       dev_clk_low = 1'b0;
    logic       dev_dat_low = 1'b0;

    always #10 CLOCK_50 = ~CLOCK_50;

    assign ps2_clk_in = ~(ps2_clk_drive_low | dev_clk_low);
    assign ps2_dat_in = ~(ps2_dat_drive_low | dev_dat_low);

    ps2_host_tx #(
        .INHIBIT_CYCLES (INH),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .CLOCK_50          (CLOCK_50),
        .reset             (reset),
        .tx_data           (tx_data),
        .tx_valid          (tx_valid),
        .tx_ready          (tx_ready),
        .tx_done           (tx_done),
        .tx_error          (tx_error),
        .busy              (busy),
        .ps2_clk_in        (ps2_clk_in),
        .ps2_dat_in        (ps2_dat_in),
        .ps2_clk_drive_low (ps2_clk_drive_low),
        .ps2_dat_drive_low (ps2_dat_drive_low)
    );

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    int done_cnt = 0, err_cnt = 0, both_cnt = 0;
    int done_cyc = 0, err_cyc = 0, acc_cyc = 0;
    int inh_run = 0, inh_len = 0, rel_cyc = 0;
    logic done_pending = 1'b0;
    logic busy_after_done = 1'b1;

    always @(posedge CLOCK_50) cyc <= cyc + 1;

    always @(negedge CLOCK_50) begin
        if (done_pending) begin
            busy_after_done = busy;
            done_pending = 1'b0;
        end
        if (tx_done) begin
            done_cnt++;
            done_cyc = cyc;
            done_pending = 1'b1;
        end
        if (tx_error) begin
            err_cnt++;
            err_cyc = cyc;
        end
        if (tx_done && tx_error) both_cnt++;
        if (tx_valid && tx_ready) acc_cyc = cyc;
        if (ps2_clk_drive_low) begin
            inh_run++;
        end else if (inh_run != 0) begin
            inh_len = inh_run;
            inh_run = 0;
            rel_cyc = cyc;
        end
    end

    initial begin
        #4000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(negedge CLOCK_50);
        #1;
    endtask

    // Expected line levels as the device sees them: start, data LSB first, odd parity, stop.
    function automatic logic [10:0] model_frame(input logic [7:0] b);
        logic [10:0] f;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) f[i+1] = b[i];
        f[9]  = ($countones(b) % 2 == 0);
        f[10] = 1'b1;
        return f;
    endfunction

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        tx_data  = b;
        tx_valid = 1'b1;
        while (!tx_ready && n < 100) begin
            tick();
            n++;
        end
        vectors++;
        if (n >= 100) begin
            miscompares++;
            $display("FAIL accept_wait: tx_ready never seen, got %0b required 1", tx_ready);
        end
        tick();
        tx_valid = 1'b0;
    endtask

    task automatic device(input int n_edges, input logic ack, output logic [10:0] bits);
        logic saw = 1'b0;
        int n = 0;
        bits = '0;
        while (n < 300) begin
            if (ps2_clk_drive_low) saw = 1'b1;
            else if (saw && ps2_dat_drive_low) break;
            tick();
            n++;
        end
        if (n >= 300) begin
            vectors++;
            miscompares++;
            $display("FAIL request_to_send: no inhibit/start seen, got clk_low=%0b dat_low=%0b",
                     ps2_clk_drive_low, ps2_dat_drive_low);
            return;
        end
        repeat (10) tick();
        bits[0] = ps2_dat_in;
        for (int e = 1; e <= n_edges; e++) begin
            dev_clk_low = 1'b1;
            repeat (HALF) tick();
            dev_clk_low = 1'b0;
            if (e <= 10) bits[e] = ps2_dat_in;
            if (e == 10) begin
                repeat (HALF / 2) tick();
                dev_dat_low = ack;
                repeat (HALF / 2) tick();
            end else begin
                repeat (HALF) tick();
            end
        end
        dev_dat_low = 1'b0;
    endtask

    task automatic wait_outcome(input int d0, input int e0);
        int n = 0;
        while ((done_cnt + err_cnt) == (d0 + e0) && n < 300) begin
            tick();
            n++;
        end
        repeat (10) tick();
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) tick();
        vectors++;
        if (tx_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_ready: got %0b required 0", tx_ready);
        end
        vectors++;
        if ({busy, tx_done, tx_error, ps2_clk_drive_low, ps2_dat_drive_low} !== 5'b0) begin
            miscompares++;
            $display("FAIL reset_outputs: got %05b required 00000",
                     {busy, tx_done, tx_error, ps2_clk_drive_low, ps2_dat_drive_low});
        end
        reset = 1'b0;
        tick();
        vectors++;
        if (tx_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL ready_after_reset: got %0b required 1", tx_ready);
        end
    endtask

    task automatic test_send_ed;
        int d0 = done_cnt, e0 = err_cnt;
        logic [10:0] bits;
        send_byte(8'hED);
        device(11, 1'b1, bits);
        wait_outcome(d0, e0);
        vectors++;
        if (inh_len != INH) begin
            miscompares++;
            $display("FAIL inhibit_len: got %0d required %0d", inh_len, INH);
        end
        vectors++;
        if (bits !== model_frame(8'hED)) begin
            miscompares++;
            $display("FAIL frame_ED: got %011b required %011b", bits, model_frame(8'hED));
        end
        vectors++;
        if (done_cnt - d0 != 1 || err_cnt - e0 != 0) begin
            miscompares++;
            $display("FAIL outcome_ED: got done=%0d err=%0d required done=1 err=0",
                     done_cnt - d0, err_cnt - e0);
        end
        vectors++;
        if ({ps2_clk_drive_low, ps2_dat_drive_low} !== 2'b00) begin
            miscompares++;
            $display("FAIL released_ED: got %02b required 00", {ps2_clk_drive_low, ps2_dat_drive_low});
        end
    endtask

    task automatic test_send_f4;
        int d0 = done_cnt, e0 = err_cnt;
        logic [10:0] bits;
        logic [10:0] exp_f;
        exp_f = model_frame(8'hF4);
        send_byte(8'hF4);
        device(11, 1'b1, bits);
        wait_outcome(d0, e0);
        vectors++;
        if (bits[9] !== exp_f[9]) begin
            miscompares++;
            $display("FAIL parity_F4: got %0b required %0b", bits[9], exp_f[9]);
        end
        vectors++;
        if (bits !== exp_f) begin
            miscompares++;
            $display("FAIL frame_F4: got %011b required %011b", bits, exp_f);
        end
        vectors++;
        if (done_cnt - d0 != 1 || err_cnt - e0 != 0) begin
            miscompares++;
            $display("FAIL outcome_F4: got done=%0d err=%0d required done=1 err=0",
                     done_cnt - d0, err_cnt - e0);
        end
        vectors++;
        if (busy_after_done !== 1'b0) begin
            miscompares++;
            $display("FAIL busy_after_done: got %0b required 0", busy_after_done);
        end
    endtask

    task automatic test_timeout;
        int d0 = done_cnt, e0 = err_cnt;
        int n = 0;
        send_byte(8'h5A);
        while (err_cnt == e0 && n < int'(TMO) + 200) begin
            tick();
            n++;
        end
        tick();
        vectors++;
        if (err_cnt - e0 != 1 || done_cnt - d0 != 0) begin
            miscompares++;
            $display("FAIL timeout_outcome: got done=%0d err=%0d required done=0 err=1",
                     done_cnt - d0, err_cnt - e0);
        end
        vectors++;
        if (err_cyc - rel_cyc < int'(TMO) - 1 || err_cyc - rel_cyc > int'(TMO) + 1) begin
            miscompares++;
            $display("FAIL timeout_delay: got %0d cycles required %0d+-1", err_cyc - rel_cyc, TMO);
        end
        vectors++;
        if ({ps2_clk_drive_low, ps2_dat_drive_low, tx_ready} !== 3'b001) begin
            miscompares++;
            $display("FAIL timeout_idle: got clk/dat/ready=%03b required 001",
                     {ps2_clk_drive_low, ps2_dat_drive_low, tx_ready});
        end
    endtask

    task automatic test_no_ack;
        int d0 = done_cnt, e0 = err_cnt;
        logic [10:0] bits;
        send_byte(8'hF4);
        device(11, 1'b0, bits);
        wait_outcome(d0, e0);
        vectors++;
        if (err_cnt - e0 != 1 || done_cnt - d0 != 0) begin
            miscompares++;
            $display("FAIL no_ack_outcome: got done=%0d err=%0d required done=0 err=1",
                     done_cnt - d0, err_cnt - e0);
        end
        vectors++;
        if (bits !== model_frame(8'hF4)) begin
            miscompares++;
            $display("FAIL no_ack_frame: got %011b required %011b", bits, model_frame(8'hF4));
        end
    endtask

    task automatic test_reset_mid_frame;
        int d0, e0;
        logic [10:0] bits;
        logic [10:0] exp_f;
        exp_f = model_frame(8'hAA);
        send_byte(8'hAA);
        device(5, 1'b1, bits);
        vectors++;
        if (bits[5:0] !== exp_f[5:0]) begin
            miscompares++;
            $display("FAIL partial_AA: got %06b required %06b", bits[5:0], exp_f[5:0]);
        end
        d0 = done_cnt;
        e0 = err_cnt;
        reset = 1'b1;
        tick();
        vectors++;
        if ({ps2_clk_drive_low, ps2_dat_drive_low, busy} !== 3'b000) begin
            miscompares++;
            $display("FAIL mid_reset_release: got clk/dat/busy=%03b required 000",
                     {ps2_clk_drive_low, ps2_dat_drive_low, busy});
        end
        reset = 1'b0;
        repeat (50) tick();
        vectors++;
        if (done_cnt != d0 || err_cnt != e0) begin
            miscompares++;
            $display("FAIL mid_reset_pulses: got done=%0d err=%0d required 0 0",
                     done_cnt - d0, err_cnt - e0);
        end
        send_byte(8'h55);
        device(11, 1'b1, bits);
        wait_outcome(d0, e0);
        vectors++;
        if (bits !== model_frame(8'h55) || done_cnt - d0 != 1 || err_cnt != e0) begin
            miscompares++;
            $display("FAIL after_reset_55: got frame %011b done=%0d err=%0d required %011b done=1 err=0",
                     bits, done_cnt - d0, err_cnt - e0, model_frame(8'h55));
        end
    endtask

    task automatic test_back_to_back;
        int d0 = done_cnt, e0 = err_cnt;
        int n = 0;
        logic [10:0] b1, b2;
        tx_data  = 8'hED;
        tx_valid = 1'b1;
        while (!tx_ready && n < 100) begin
            tick();
            n++;
        end
        tick();
        tx_data = 8'h00;
        device(11, 1'b1, b1);
        n = 0;
        while (done_cnt == d0 && err_cnt == e0 && n < 300) begin
            tick();
            n++;
        end
        tick();
        tick();
        tx_valid = 1'b0;
        vectors++;
        if (acc_cyc != done_cyc + 1) begin
            miscompares++;
            $display("FAIL b2b_accept: got accept at +%0d required +1", acc_cyc - done_cyc);
        end
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_busy: got %0b required 1", busy);
        end
        device(11, 1'b1, b2);
        wait_outcome(d0 + 1, e0);
        vectors++;
        if (b1 !== model_frame(8'hED)) begin
            miscompares++;
            $display("FAIL b2b_frame1: got %011b required %011b", b1, model_frame(8'hED));
        end
        vectors++;
        if (b2 !== model_frame(8'h00)) begin
            miscompares++;
            $display("FAIL b2b_frame2: got %011b required %011b", b2, model_frame(8'h00));
        end
        vectors++;
        if (done_cnt - d0 != 2 || err_cnt != e0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_outcome: got done=%0d err=%0d busy=%0b required done=2 err=0 busy=0",
                     done_cnt - d0, err_cnt - e0, busy);
        end
    endtask

    task automatic test_random;
        for (int k = 0; k < 5; k++) begin
            int d0 = done_cnt, e0 = err_cnt;
            logic [7:0] b;
            logic ack;
            logic [10:0] bits;
            b   = 8'($urandom);
            ack = ($urandom_range(0, 3) != 0);
            send_byte(b);
            device(11, ack, bits);
            wait_outcome(d0, e0);
            vectors++;
            if (bits !== model_frame(b)) begin
                miscompares++;
                $display("FAIL rand_frame_%02h: got %011b required %011b", b, bits, model_frame(b));
            end
            vectors++;
            if (done_cnt - d0 != int'(ack) || err_cnt - e0 != int'(!ack)) begin
                miscompares++;
                $display("FAIL rand_outcome_%02h: got done=%0d err=%0d required done=%0d err=%0d",
                         b, done_cnt - d0, err_cnt - e0, int'(ack), int'(!ack));
            end
        end
    endtask

    initial begin
        test_reset();
        test_send_ed();
        test_send_f4();
        test_timeout();
        test_no_ack();
        test_reset_mid_frame();
        test_back_to_back();
        test_random();
        vectors++;
        if (both_cnt != 0) begin
            miscompares++;
            $display("FAIL done_error_overlap: got %0d cycles required 0", both_cnt);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
